// File: rtl/instr_fetch_if.sv
// Bundle of the fetch unit's PC, instruction-memory and decode-side signals.
// The fetch unit connects through the master modport; the environment uses slave.
interface instr_fetch_if;
  logic [31:0] pc;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_advance;
  logic        fault;
  logic [31:0] fault_addr;

  modport master (
    input  pc, redirect, imem_gnt, imem_rvalid, imem_rdata, imem_err, instr_ready,
    output imem_req, imem_addr, instr, instr_pc, instr_valid, pc_advance, fault, fault_addr
  );

  modport slave (
    output pc, redirect, imem_gnt, imem_rvalid, imem_rdata, imem_err, instr_ready,
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, pc_advance, fault, fault_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: issues one imem request at a time,
// holds the fetched word for decode, squashes on redirect and traps fetch faults.
module instr_fetch #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic        imem_req_s;
  logic        pc_advance_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= REQ;
      discard_q    <= 1'b0;
      instr_q      <= NOP_INSTR;
      instr_pc_q   <= 32'h0000_0000;
      fault_addr_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    fault_addr_d = fault_addr_q;
    imem_req_s   = 1'b0;
    pc_advance_s = 1'b0;

    case (state_q)
      REQ: begin
        if (bus.pc[1:0] != 2'b00) begin
          fault_addr_d = bus.pc;
          state_d      = FAULT;
        end else begin
          imem_req_s = 1'b1;
          if (bus.imem_gnt) begin
            // A redirect in the grant cycle means the granted address is already stale.
            instr_pc_d = bus.pc;
            discard_d  = bus.redirect;
            state_d    = WAIT;
          end else begin
            state_d = REQ;
          end
        end
      end

      WAIT: begin
        if (bus.imem_rvalid) begin
          if (discard_q || bus.redirect) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else if (bus.imem_err) begin
            fault_addr_d = instr_pc_q;
            state_d      = FAULT;
          end else begin
            instr_d = bus.imem_rdata;
            state_d = HOLD;
          end
        end else begin
          if (bus.redirect) begin
            discard_d = 1'b1;
          end else begin
            discard_d = discard_q;
          end
          state_d = WAIT;
        end
      end

      HOLD: begin
        // Redirect wins over acceptance: the held instruction is on the wrong path.
        if (bus.redirect) begin
          state_d = REQ;
        end else if (bus.instr_ready) begin
          pc_advance_s = 1'b1;
          state_d      = REQ;
        end else begin
          state_d = HOLD;
        end
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d = REQ;
      end
    endcase
  end

  assign bus.imem_req    = imem_req_s;
  assign bus.imem_addr   = bus.pc;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr       = (state_q == HOLD) ? instr_q : NOP_INSTR;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_advance  = pc_advance_s;
  assign bus.fault       = (state_q == FAULT);
  assign bus.fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  instr_fetch_if bus ();

  instr_fetch #(.NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.redirect    = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0000_0000;
    bus.imem_err    = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.pc = 32'h0000_0000;
    bus.instr_ready = 1'b0;
    idle_inputs();
    #3;
    chk("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_fault", {31'd0, bus.fault}, 32'd0);
    chk("rst_fault_addr", bus.fault_addr, 32'h0);
    chk("rst_pc_advance", {31'd0, bus.pc_advance}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Zero-wait fetch at pc 0
    bus.imem_gnt = 1'b1;
    bus.instr_ready = 1'b1;
    settle();
    chk("zw_req", {31'd0, bus.imem_req}, 32'd1);
    chk("zw_addr", bus.imem_addr, 32'h0);
    tick();
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    settle();
    chk("zw_c1_req", {31'd0, bus.imem_req}, 32'd0);
    chk("zw_c1_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("zw_c1_adv", {31'd0, bus.pc_advance}, 32'd0);
    tick();
    idle_inputs();
    settle();
    chk("zw_c2_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("zw_c2_instr", bus.instr, 32'h0050_0093);
    chk("zw_c2_instr_pc", bus.instr_pc, 32'h0);
    chk("zw_c2_adv", {31'd0, bus.pc_advance}, 32'd1);
    tick();
    bus.pc = 32'h0000_0004;
    settle();
    chk("zw_c3_adv", {31'd0, bus.pc_advance}, 32'd0);
    chk("zw_c3_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("zw_c3_instr", bus.instr, NOP);
    chk("zw_c3_req", {31'd0, bus.imem_req}, 32'd1);
    chk("zw_c3_addr", bus.imem_addr, 32'h4);

    // Backpressure in HOLD
    bus.imem_gnt = 1'b1;
    bus.instr_ready = 1'b0;
    tick();
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h00a0_0113;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("bp_instr", bus.instr, 32'h00a0_0113);
      chk("bp_instr_pc", bus.instr_pc, 32'h4);
      chk("bp_adv", {31'd0, bus.pc_advance}, 32'd0);
      chk("bp_req", {31'd0, bus.imem_req}, 32'd0);
      tick();
    end
    bus.instr_ready = 1'b1;
    settle();
    chk("bp_accept_adv", {31'd0, bus.pc_advance}, 32'd1);
    tick();
    bus.pc = 32'h0000_0008;
    settle();
    chk("bp_after_adv", {31'd0, bus.pc_advance}, 32'd0);
    chk("bp_after_req", {31'd0, bus.imem_req}, 32'd1);

    // Redirect while waiting for the response
    bus.pc = 32'h0000_0010;
    bus.imem_gnt = 1'b1;
    settle();
    chk("rw_addr", bus.imem_addr, 32'h10);
    tick();
    bus.imem_gnt = 1'b0;
    bus.redirect = 1'b1;
    settle();
    chk("rw_req_wait", {31'd0, bus.imem_req}, 32'd0);
    tick();
    bus.redirect = 1'b0;
    bus.pc = 32'h0000_0040;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rw_wait_req", {31'd0, bus.imem_req}, 32'd0);
      tick();
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("rw_rvalid_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    idle_inputs();
    settle();
    chk("rw_dropped_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rw_dropped_instr", bus.instr, NOP);
    chk("rw_new_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rw_new_addr", bus.imem_addr, 32'h40);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h1111_1111;
    tick();
    idle_inputs();
    settle();
    chk("rw_fetch_instr", bus.instr, 32'h1111_1111);
    chk("rw_fetch_pc", bus.instr_pc, 32'h40);
    chk("rw_fetch_adv", {31'd0, bus.pc_advance}, 32'd1);
    tick();
    bus.pc = 32'h0000_0044;

    // Redirect in the same cycle as the grant
    bus.imem_gnt = 1'b1;
    bus.redirect = 1'b1;
    settle();
    chk("rg_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rg_addr", bus.imem_addr, 32'h44);
    tick();
    idle_inputs();
    bus.pc = 32'h0000_0080;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hBADB_AD00;
    tick();
    idle_inputs();
    settle();
    chk("rg_dropped_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rg_new_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rg_new_addr", bus.imem_addr, 32'h80);

    // A stray response while in REQ must be ignored
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    settle();
    chk("stray_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("stray_req", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h2222_2222;
    tick();
    idle_inputs();
    settle();
    chk("rg_fetch_instr", bus.instr, 32'h2222_2222);
    chk("rg_fetch_pc", bus.instr_pc, 32'h80);

    // Redirect in HOLD beats instr_ready
    bus.redirect = 1'b1;
    settle();
    chk("rh_adv", {31'd0, bus.pc_advance}, 32'd0);
    tick();
    bus.redirect = 1'b0;
    bus.pc = 32'h0000_0100;
    settle();
    chk("rh_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rh_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rh_addr", bus.imem_addr, 32'h100);

    // Bus error on fetch of 0x20
    bus.pc = 32'h0000_0020;
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_err = 1'b1;
    bus.imem_rdata = 32'h3333_3333;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.imem_gnt = 1'b1;
      bus.imem_rvalid = 1'(i % 2);
      settle();
      chk("be_fault", {31'd0, bus.fault}, 32'd1);
      chk("be_fault_addr", bus.fault_addr, 32'h20);
      chk("be_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("be_req", {31'd0, bus.imem_req}, 32'd0);
      tick();
    end
    idle_inputs();
    rst_n = 1'b0;
    settle();
    chk("be_rst_fault", {31'd0, bus.fault}, 32'd0);
    chk("be_rst_fault_addr", bus.fault_addr, 32'h0);
    tick();
    rst_n = 1'b1;

    // Misaligned fetch at pc 0x6
    bus.pc = 32'h0000_0006;
    bus.imem_gnt = 1'b1;
    settle();
    chk("ma_req", {31'd0, bus.imem_req}, 32'd0);
    chk("ma_fault_pre", {31'd0, bus.fault}, 32'd0);
    tick();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.imem_rvalid = 1'b1;
      bus.redirect = 1'(i % 2);
      bus.pc = 32'h0000_0200;
      settle();
      chk("ma_fault", {31'd0, bus.fault}, 32'd1);
      chk("ma_fault_addr", bus.fault_addr, 32'h6);
      chk("ma_req_hold", {31'd0, bus.imem_req}, 32'd0);
      chk("ma_adv", {31'd0, bus.pc_advance}, 32'd0);
      chk("ma_valid", {31'd0, bus.instr_valid}, 32'd0);
      tick();
    end
    idle_inputs();
    bus.pc = 32'h0000_0000;
    rst_n = 1'b0;
    settle();
    chk("ma_rst_fault", {31'd0, bus.fault}, 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("ma_post_req", {31'd0, bus.imem_req}, 32'd1);
    chk("ma_post_addr", bus.imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Single-outstanding instruction fetch unit between the program counter and instruction memory. It samples the current PC and issues a request on a req/gnt/rvalid instruction-memory handshake. It captures the returned word into an instruction register and presents it to decode with a valid/ready handshake. It also tells the PC when to advance, squashes in-flight fetches on control-flow redirects, and traps misaligned or bus-error fetches.

## Interface
Parameters:
- NOP_INSTR, 32'h0000_0013, value driven on `instr` whenever `instr_valid` is low (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc  in  32  current program counter (registered in PC block).
- redirect  in  1  jump/jalr/taken branch resolved this cycle; PC loads target at next edge.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response data.
- imem_err  in  1  bus error, qualified by imem_rvalid.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address of `instr`.
- instr_valid  out  1  `instr`/`instr_pc` valid for decode.
- instr_ready  in  1  decode accepts instruction.
- pc_advance  out  1  PC may update at next edge; PC holds when low and `redirect` is low.
- fault  out  1  sticky fetch fault.
- fault_addr  out  32  PC of faulting fetch.

## Operation
- **States:** REQ, WAIT, HOLD, FAULT. Reset state is REQ.
- **REQ:** `imem_req`=1 and `imem_addr`=`pc` (combinational).
  - `pc[1:0]`≠0: no request (`imem_req`=0). Load `fault_addr`=`pc`, go to FAULT.
  - `imem_gnt`=1: latch `pc` into `instr_pc` register, go to WAIT. Set the discard flag if `redirect`=1 in the same cycle, because the granted address is stale.
  - Otherwise stay in REQ.
- **WAIT:** `imem_req`=0. `redirect`=1 sets the discard flag. On `imem_rvalid`:
  - Discard flag set, or `redirect`=1 this cycle: drop the response, clear the flag, go to REQ.
  - Else if `imem_err`: `fault_addr`=`instr_pc`, go to FAULT.
  - Else: `instr`←`imem_rdata`, go to HOLD.
- **HOLD:** `instr_valid`=1.
  - `redirect`=1: drop the instruction (`instr_valid` low next cycle), go to REQ. Redirect wins over `instr_ready`.
  - Else if `instr_ready`: `pc_advance`=1 for this cycle only, go to REQ.
  - `instr` and `instr_pc` are held stable while `instr_valid`=1 and not accepted.
- **FAULT:** `fault`=1, `instr_valid`=0, `imem_req`=0, `pc_advance`=0. All inputs are ignored. Only reset exits this state.
- **Other rules:**
  - `imem_rvalid` outside WAIT is ignored.
  - At most one request is outstanding.
  - `pc_advance` = (state==HOLD) & `instr_ready` & !`redirect`.

## Timing
- **Reset values (async assertion):** state=REQ, `instr_valid`=0, `instr`=NOP_INSTR, `instr_pc`=0, `fault`=0, `fault_addr`=0, discard flag=0, `pc_advance`=0.
- **Behaviour after reset:** `imem_req`=1 and `imem_addr`=`pc` are asserted combinationally in the first cycle after release.
- **Zero-wait memory:**
  - gnt at cycle N, rvalid at N+1, `instr_valid` high at N+2.
  - Accepted at N+2 gives `pc_advance` at N+2, and the next request is issued at N+3.
  - Peak throughput is 1 instruction per 3 cycles.
- **Arbitrary latency:** the unit stays in REQ any number of cycles awaiting gnt, and in WAIT any number of cycles awaiting rvalid.
- **Reset mid-transaction:** state returns to REQ. Any late rvalid arrives outside WAIT and is ignored, so the memory must not return a stale response to the new first request.

## Test plan
- **Zero-wait fetch:** pc=0x0, gnt and rvalid immediate, rdata=0x00500093, ready=1 → imem_addr=0x0 at cycle 0; instr_valid at cycle 2 with instr=0x00500093 and instr_pc=0x0; pc_advance=1 at cycle 2 only.
- **Backpressure:** instr_ready=0 for 4 cycles in HOLD → instr and instr_pc stable, pc_advance=0, imem_req=0 throughout; one-cycle pc_advance when ready rises.
- **Redirect in WAIT:** gnt at pc=0x10, redirect pulsed, rvalid 3 cycles later with rdata=0xDEADBEEF → no instr_valid; next request uses the new pc=0x40.
- **Redirect with gnt:** redirect and gnt in the same REQ cycle → that response is discarded; the following request carries the target pc.
- **Misaligned fetch:** pc=0x6 → imem_req=0; fault=1 next cycle with fault_addr=0x6; fault stays high for 10 cycles until rst_n is pulsed low.
- **Bus error:** rvalid with imem_err=1 for pc=0x20 → fault=1, fault_addr=0x20, instr_valid never asserts.
